// File: rtl/serial_flow_adder.sv
// serial_flow_adder: LANES independent bit-serial adders sharing one frame
// protocol. Each frame is WIDTH beats, LSB first, opened by sof. Each beat
// produces a registered serial sum bit one cycle later. The completed
// parallel sum and per-lane overflow flags are published with the final bit.
//
// Configuration macro: SFA_SIGNED_OVF_EN
//   undefined : overflw = unsigned carry out of bit WIDTH-1
//   defined   : overflw = two's-complement overflow (carry into MSB ^ carry out)
module serial_flow_adder #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     sof,
  input  logic [LANES-1:0]         line1,
  input  logic [LANES-1:0]         line2,
  output logic [LANES-1:0]         outp,
  output logic                     out_valid,
  output logic                     eof,
  output logic [LANES*WIDTH-1:0]   sum,
  output logic                     sum_valid,
  output logic [LANES-1:0]         overflw,
  output logic                     err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         bit_idx;
  logic [LANES-1:0]         carry;
  logic [LANES*WIDTH-1:0]   partial;

  logic                     start;
  logic                     process;
  logic                     proto_err;
  logic                     is_last;
  logic [IDX_W-1:0]         idx_cur;
  logic [LANES-1:0]         cin_vec;
  logic [LANES-1:0]         s_vec;
  logic [LANES-1:0]         c_vec;
  logic [LANES-1:0]         ovf_vec;
  logic [LANES*WIDTH-1:0]   next_partial;

  // Beat decode and one full-adder step per lane for the bit being processed.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // can leave a value unassigned and infer a latch.
    start        = in_valid & sof;
    process      = in_valid & (sof | (state == RUN));
    proto_err    = in_valid & (sof ? (state == RUN) : (state == IDLE));
    idx_cur      = start ? '0 : bit_idx;
    is_last      = (idx_cur == LAST_IDX);
    cin_vec      = start ? '0 : carry;
    s_vec        = line1 ^ line2 ^ cin_vec;
    c_vec        = (line1 & line2) | (line1 & cin_vec) | (line2 & cin_vec);
    next_partial = partial;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (idx_cur == IDX_W'(i)) next_partial[k*WIDTH + i] = s_vec[k];
      end
    end
`ifdef SFA_SIGNED_OVF_EN
    ovf_vec = cin_vec ^ c_vec;
`else
    ovf_vec = c_vec;
`endif
  end

  // Frame FSM, carry chain and all registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      carry     <= '0;
      outp      <= '0;
      out_valid <= 1'b0;
      eof       <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      overflw   <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      eof       <= 1'b0;
      sum_valid <= 1'b0;
      err       <= proto_err;
      if (process) begin
        outp      <= s_vec;
        out_valid <= 1'b1;
        eof       <= is_last;
        if (is_last) begin
          state     <= IDLE;
          bit_idx   <= '0;
          carry     <= '0;
          sum       <= next_partial;
          sum_valid <= 1'b1;
          overflw   <= ovf_vec;
        end else begin
          state   <= RUN;
          bit_idx <= idx_cur + IDX_W'(1);
          carry   <= c_vec;
        end
      end
    end
  end

  // Partial-sum accumulator for the open frame.
  always_ff @(posedge clock) begin
    // NOTE: no reset here on purpose: every bit is rewritten during a frame
    // before it can reach sum, so stale contents are never observable.
    if (process) partial <= next_partial;
  end

endmodule

// File: tb/tb_serial_flow_adder.sv
// Self-checking bench for serial_flow_adder (WIDTH=8, LANES=2). Expected
// serial bits, results and error pulses are derived from integer addition
// and queued with the cycle in which they must appear; a negedge monitor
// compares them against the DUT every cycle.
module tb_serial_flow_adder;

  localparam int W = 8;
  localparam int L = 2;

`ifdef SFA_SIGNED_OVF_EN
  localparam bit SIGNED_OVF = 1'b1;
`else
  localparam bit SIGNED_OVF = 1'b0;
`endif

  typedef struct {
    int             cyc;
    logic [L-1:0]   bits;
    logic           eof;
  } beat_t;

  typedef struct {
    int             cyc;
    logic [L*W-1:0] sum;
    logic [L-1:0]   ovf;
  } res_t;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             sof;
  logic [L-1:0]     line1;
  logic [L-1:0]     line2;
  logic [L-1:0]     outp;
  logic             out_valid;
  logic             eof;
  logic [L*W-1:0]   sum;
  logic             sum_valid;
  logic [L-1:0]     overflw;
  logic             err;

  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  bit               mon_en = 1'b0;
  bit               open_frame = 1'b0;
  logic [L*W-1:0]   hold_sum = '0;
  logic [L-1:0]     hold_ovf = '0;

  beat_t            bq[$];
  res_t             rq[$];
  int               eq[$];

  serial_flow_adder #(.WIDTH(W), .LANES(L)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .sof       (sof),
    .line1     (line1),
    .line2     (line2),
    .outp      (outp),
    .out_valid (out_valid),
    .eof       (eof),
    .sum       (sum),
    .sum_valid (sum_valid),
    .overflw   (overflw),
    .err       (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Cycle-accurate scoreboard monitor.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        beat_t b;
        res_t  r;
        bit    exp_ov;
        bit    exp_sv;
        bit    exp_err;
        while (bq.size() > 0 && bq[0].cyc < cyc) void'(bq.pop_front());
        while (rq.size() > 0 && rq[0].cyc < cyc) void'(rq.pop_front());
        while (eq.size() > 0 && eq[0] < cyc) void'(eq.pop_front());
        exp_ov  = (bq.size() > 0 && bq[0].cyc == cyc);
        exp_sv  = (rq.size() > 0 && rq[0].cyc == cyc);
        exp_err = (eq.size() > 0 && eq[0] == cyc);

        tests++;
        if (out_valid !== exp_ov) begin
          fails++;
          $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_ov);
        end
        if (exp_ov) begin
          b = bq.pop_front();
          tests++;
          if (outp !== b.bits || eof !== b.eof) begin
            fails++;
            $display("FAIL outp/eof cyc %0d: got %b/%b expected %b/%b", cyc, outp, eof, b.bits, b.eof);
          end
        end else begin
          tests++;
          if (eof !== 1'b0) begin
            fails++;
            $display("FAIL eof_idle cyc %0d: got %b expected 0", cyc, eof);
          end
        end

        tests++;
        if (sum_valid !== exp_sv) begin
          fails++;
          $display("FAIL sum_valid cyc %0d: got %b expected %b", cyc, sum_valid, exp_sv);
        end
        if (exp_sv) begin
          r = rq.pop_front();
          hold_sum = r.sum;
          hold_ovf = r.ovf;
        end
        tests++;
        if (sum !== hold_sum || overflw !== hold_ovf) begin
          fails++;
          $display("FAIL sum/overflw cyc %0d: got %h/%b expected %h/%b", cyc, sum, overflw, hold_sum, hold_ovf);
        end

        tests++;
        if (err !== exp_err) begin
          fails++;
          $display("FAIL err cyc %0d: got %b expected %b", cyc, err, exp_err);
        end
        if (exp_err) void'(eq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [L-1:0] a,
                       input logic [L-1:0] b, input logic r);
    reset    = r;
    in_valid = v;
    sof      = s;
    line1    = a;
    line2    = b;
    tick();
  endtask

  task automatic idle_beat();
    drive(1'b0, 1'($urandom), L'($urandom), L'($urandom), 1'b0);
  endtask

  // Drives n beats of frame a+b (sof on the first), optionally stalling
  // stall_len cycles after beat stall_at, and queues every expectation.
  task automatic send_beats(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                            input int n, input int stall_at, input int stall_len);
    logic [W:0]     t[L];
    logic [L*W-1:0] es;
    logic [L-1:0]   eo;
    logic [L-1:0]   ab;
    logic [L-1:0]   bb;
    logic [L-1:0]   eb;
    for (int k = 0; k < L; k++) begin
      logic [W-1:0] ak;
      logic [W-1:0] bk;
      ak = a[k*W +: W];
      bk = b[k*W +: W];
      t[k] = {1'b0, ak} + {1'b0, bk};
      es[k*W +: W] = t[k][W-1:0];
      if (SIGNED_OVF) eo[k] = (ak[W-1] == bk[W-1]) && (t[k][W-1] != ak[W-1]);
      else            eo[k] = t[k][W];
    end
    if (open_frame) eq.push_back(cyc + 1);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < L; k++) begin
        ab[k] = a[k*W + i];
        bb[k] = b[k*W + i];
        eb[k] = t[k][i];
      end
      bq.push_back('{cyc: cyc + 1, bits: eb, eof: (i == W - 1)});
      if (i == W - 1) rq.push_back('{cyc: cyc + 1, sum: es, ovf: eo});
      drive(1'b1, (i == 0), ab, bb, 1'b0);
      if (i == stall_at) repeat (stall_len) idle_beat();
    end
    open_frame = (n < W);
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    drive(1'b1, 1'b1, '1, '1, 1'b1);
    tick();
    @(negedge clock);
    tests++;
    if (outp !== '0 || out_valid !== 1'b0 || eof !== 1'b0) begin
      fails++;
      $display("FAIL reset_serial: got outp %b ov %b eof %b expected 0", outp, out_valid, eof);
    end
    tests++;
    if (sum !== '0 || sum_valid !== 1'b0 || overflw !== '0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_parallel: got sum %h sv %b ovf %b err %b expected 0", sum, sum_valid, overflw, err);
    end
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    sof      = 1'b0;
    hold_sum = '0;
    hold_ovf = '0;
    open_frame = 1'b0;
    mon_en   = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_beats(16'h1005, 16'h2003, W, -1, 0);
    tests++;
    if (sum !== 16'h3008 || overflw !== 2'b00 || sum_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic: got sum %h ovf %b sv %b expected 3008 00 1", sum, overflw, sum_valid);
    end
    idle_beat();
  endtask

  task automatic test_overflow();
    logic [L-1:0] want;
    want = SIGNED_OVF ? 2'b10 : 2'b01;
    send_beats(16'h7FFF, 16'h0101, W, -1, 0);
    tests++;
    if (sum !== 16'h8000 || overflw !== want) begin
      fails++;
      $display("FAIL overflow: got sum %h ovf %b expected 8000 %b", sum, overflw, want);
    end
    idle_beat();
  endtask

  task automatic test_stall();
    int start;
    start = cyc;
    send_beats(16'h0005, 16'h0003, W, 3, 3);
    // Result is visible 11 edges after the first beat was driven, i.e. in the
    // twelfth cycle counting the first beat's cycle as cycle 1.
    tests++;
    if (sum[W-1:0] !== 8'h08 || sum_valid !== 1'b1 || (cyc - start) != 11) begin
      fails++;
      $display("FAIL stall: got sum %h sv %b after %0d cycles expected 08 1 11", sum[W-1:0], sum_valid, cyc - start);
    end
    idle_beat();
  endtask

  task automatic test_abort();
    send_beats(16'h3355, 16'h11AA, 4, -1, 0);
    send_beats(16'h0101, 16'h0101, W, -1, 0);
    tests++;
    if (sum[W-1:0] !== 8'h02) begin
      fails++;
      $display("FAIL abort: got lane0 sum %h expected 02", sum[W-1:0]);
    end
    idle_beat();
  endtask

  task automatic test_reset_mid();
    send_beats(16'h4477, 16'h2211, 5, -1, 0);
    drive(1'b1, 1'b0, '1, '1, 1'b1);
    hold_sum   = '0;
    hold_ovf   = '0;
    open_frame = 1'b0;
    @(negedge clock);
    tests++;
    if (outp !== '0 || out_valid !== 1'b0 || eof !== 1'b0 || sum !== '0 ||
        sum_valid !== 1'b0 || overflw !== '0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got outp %b ov %b eof %b sum %h sv %b ovf %b err %b expected all 0",
               outp, out_valid, eof, sum, sum_valid, overflw, err);
    end
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    send_beats(16'h300A, 16'h4005, W, -1, 0);
    tests++;
    if (sum[W-1:0] !== 8'h0F || overflw[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_next: got lane0 sum %h ovf %b expected 0f 0", sum[W-1:0], overflw[0]);
    end
    idle_beat();
  endtask

  task automatic test_idle_err();
    // Two stray beats: the second only errors if the first left the FSM idle.
    repeat (2) begin
      eq.push_back(cyc + 1);
      drive(1'b1, 1'b0, L'($urandom), L'($urandom), 1'b0);
    end
    idle_beat();
    idle_beat();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 10; f++) begin
      int sa;
      sa = (f % 3 == 0) ? int'($urandom_range(0, W - 2)) : -1;
      send_beats(16'($urandom), 16'($urandom), W, sa, int'($urandom_range(1, 3)));
    end
    send_beats(16'hFFFF, 16'hFFFF, W, -1, 0);
    send_beats(16'h8080, 16'h8080, W, -1, 0);
    send_beats(16'h0000, 16'h0000, W, -1, 0);
    idle_beat();
    idle_beat();
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    sof      = 1'b0;
    line1    = '0;
    line2    = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_abort();
    test_reset_mid();
    test_idle_err();
    test_back_to_back();
    repeat (3) idle_beat();
    tests++;
    if (bq.size() != 0 || rq.size() != 0 || eq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d/%0d pending expected 0/0/0", bq.size(), rq.size(), eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_flow_adder.md
SERIAL_FLOW_ADDER -- requirements
Module: serial_flow_adder

Interface
REQ-001 Parameter SHALL be: WIDTH, 8, frame length in bits per operand (legal 2..32).
REQ-002 Parameter SHALL be: LANES, 2, number of independent serial adder lanes (legal 1..8).
REQ-003 Port SHALL be: clock  input  1  rising-edge clock.
REQ-004 Port SHALL be: reset  input  1  reset, synchronous, active-high.
REQ-005 Port SHALL be: in_valid  input  1  beat qualifier; a beat is accepted on any rising edge with in_valid=1.
REQ-006 Port SHALL be: sof  input  1  start of frame, sampled only on accepted beats.
REQ-007 Port SHALL be: line1  input  LANES  operand A bit per lane, LSB first.
REQ-008 Port SHALL be: line2  input  LANES  operand B bit per lane, LSB first.
REQ-009 Port SHALL be: outp  output  LANES  registered serial sum bit per lane.
REQ-010 Port SHALL be: out_valid  output  1  outp qualifier.
REQ-011 Port SHALL be: eof  output  1  marks the outp beat that carries bit WIDTH-1.
REQ-012 Port SHALL be: sum  output  LANES*WIDTH  parallel result; lane k in bits [k*WIDTH +: WIDTH].
REQ-013 Port SHALL be: sum_valid  output  1  single-cycle pulse qualifying sum and overflw.
REQ-014 Port SHALL be: overflw  output  LANES  per-lane overflow flag of the completed frame.
REQ-015 Port SHALL be: err  output  1  single-cycle protocol-error pulse.

Function
REQ-016 The FSM SHALL have two states: IDLE (no frame open) and RUN (frame open; bit index 1..WIDTH-1 pending).
REQ-017 In IDLE, an accepted beat with sof=1 SHALL be bit 0: carry-in 0 per lane, bit index becomes 1, state becomes RUN.
REQ-018 In IDLE, an accepted beat with sof=0 SHALL be discarded (no out_valid) and SHALL pulse err the next cycle.
REQ-019 In RUN, an accepted beat with sof=0 SHALL process the current bit index and increment it; the beat at index WIDTH-1 SHALL return the FSM to IDLE.
REQ-020 In RUN, an accepted beat with sof=1 SHALL abort the open frame (no sum_valid), pulse err next cycle, and be processed as bit 0 of a new frame.
REQ-021 Cycles with in_valid=0 SHALL hold state, bit index, carries and partial sum unchanged and SHALL drive out_valid=0.
REQ-022 Per lane, each processed beat SHALL compute s = line1^line2^carry and carry' = majority(line1,line2,carry).
REQ-023 outp, out_valid=1 and eof SHALL appear exactly one cycle after the processed beat (latency 1).
REQ-024 sum, sum_valid=1 and overflw SHALL appear in the same cycle as eof=1; sum and overflw SHALL hold until the next sum_valid or reset.
REQ-025 A new frame SHALL be acceptable on the cycle immediately after the last beat (back-to-back frames, no bubble).
REQ-026 All arithmetic SHALL be modulo 2^WIDTH per lane; lanes SHALL not interact.

Reset
REQ-027 With reset=1 on a rising edge, state SHALL become IDLE, bit index 0, all carries 0, and outp, out_valid, eof, sum, sum_valid, overflw, err SHALL all be 0.
REQ-028 Reset mid-frame SHALL discard the frame with no sum_valid; reset SHALL take priority over any beat in that cycle.

Configuration
REQ-029 With macro SFA_SIGNED_OVF_EN defined, overflw per lane SHALL be carry-into-MSB XOR carry-out-of-MSB (two's-complement overflow).
REQ-030 Without SFA_SIGNED_OVF_EN, overflw per lane SHALL be the carry out of bit WIDTH-1 (unsigned overflow).

Verification (WIDTH=8, LANES=2)
REQ-031 Lane0 0x05+0x03, lane1 0x10+0x20, 8 consecutive beats -> outp lane0 LSB-first 0,0,0,1,0,0,0,0; sum=0x3008; overflw=00; sum_valid one cycle after beat 8.
REQ-032 Lane0 0xFF+0x01, lane1 0x7F+0x01 -> sum lane0=0x00, lane1=0x80; overflw=01 without macro, overflw=10 with SFA_SIGNED_OVF_EN.
REQ-033 Frame 0x05+0x03 with in_valid=0 for 3 cycles after bit 3 -> identical sum 0x08; out_valid=0 during the 3 stall cycles; sum_valid 12 cycles after first beat.
REQ-034 sof=1 reasserted on bit 4 -> err=1 one cycle later, no sum_valid for aborted frame; following 8-beat frame 0x01+0x01 yields sum lane0=0x02.
REQ-035 reset=1 during bit 5 -> next cycle all outputs 0, no sum_valid; subsequent frame 0x0A+0x05 yields sum lane0=0x0F, overflw=0.
REQ-036 Accepted beat with sof=0 in IDLE -> err=1 one cycle later, out_valid=0, state remains IDLE.
